// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: merges stage stall requests, sequences (possibly deferred) exception
// flushes, holds EX for multi-cycle MDU ops and runs a sticky stall watchdog.
package pipeline_ctrl_pkg;
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
  } Stall_t;
endpackage

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 36,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_if,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        mdu_start,
  input  logic        except_occur,
  input  logic [31:0] except_vec,
  output Stall_t      stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        mdu_done,
  output logic        stall_timeout
);

  localparam int MW = $clog2(MDU_CYCLES);
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {RUN, MDU_BUSY, EXC_PEND} state_t;

  state_t          state;
  logic [MW-1:0]   mdu_cnt;
  logic [31:0]     pend_vec;
  logic [WW-1:0]   wdog_cnt;
  logic            timeout_q;

  logic            exc_take;
  logic            flush_c;
  logic            mdu_go;
  logic            mdu_hold;
  logic            mdu_last;
  Stall_t          merged;
  logic [WW-1:0]   wdog_nxt;

  always_comb begin
    exc_take = (state != EXC_PEND) && except_occur;
    flush_c  = (exc_take || (state == EXC_PEND)) && !stall_req_mem;
    // An exception in the same cycle outranks a new MDU issue.
    mdu_go   = (state == RUN) && mdu_start && !except_occur;
    mdu_hold = mdu_go || (state == MDU_BUSY);
    mdu_last = (state == MDU_BUSY) && (mdu_cnt == MW'(MDU_CYCLES - 1));

    merged.stall_mem = stall_req_mem;
    merged.stall_ex  = merged.stall_mem | stall_req_ex | mdu_hold;
    merged.stall_id  = merged.stall_ex | stall_req_id;
    merged.stall_if  = merged.stall_id | stall_req_if;
    if (flush_c) merged = '0;

    if (!merged.stall_if) wdog_nxt = '0;
    else if (wdog_cnt == WW'(WDOG_LIMIT)) wdog_nxt = wdog_cnt;
    else wdog_nxt = wdog_cnt + 1'b1;
  end

  always_comb begin
    stall         = rst ? '0 : merged;
    flush         = !rst && flush_c;
    flush_pc      = (rst || !flush_c) ? 32'h0 : ((state == EXC_PEND) ? pend_vec : except_vec);
    mdu_done      = !rst && mdu_last && !except_occur;
    stall_timeout = !rst && timeout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      mdu_cnt   <= '0;
      pend_vec  <= '0;
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (flush_c) begin
        state   <= RUN;
        mdu_cnt <= '0;
      end else if (exc_take) begin
        // MEM stalled: remember the first exception and abort any MDU op.
        state    <= EXC_PEND;
        pend_vec <= except_vec;
        mdu_cnt  <= '0;
      end else if (mdu_go) begin
        state   <= MDU_BUSY;
        mdu_cnt <= MW'(1);
      end else if (state == MDU_BUSY) begin
        if (mdu_last) begin
          state   <= RUN;
          mdu_cnt <= '0;
        end else begin
          mdu_cnt <= mdu_cnt + 1'b1;
        end
      end
      wdog_cnt <= wdog_nxt;
      if (wdog_nxt == WW'(WDOG_LIMIT)) timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, watchdog sequence, then random vs. a model.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int MDU = 4;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_if = 0, req_id = 0, req_ex = 0, req_mem = 0, mdu_start = 0, except_occur = 0;
  logic [31:0] except_vec = '0;
  Stall_t stall;
  logic flush, mdu_done, stall_timeout;
  logic [31:0] flush_pc;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.MDU_CYCLES(MDU), .WDOG_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .stall_req_if(req_if), .stall_req_id(req_id), .stall_req_ex(req_ex), .stall_req_mem(req_mem),
    .mdu_start(mdu_start), .except_occur(except_occur), .except_vec(except_vec),
    .stall(stall), .flush(flush), .flush_pc(flush_pc), .mdu_done(mdu_done),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, i_if, i_id, i_ex, i_mem, ms, ex;
    logic [31:0] vec;
    logic [3:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_done, e_to;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic i_if, input logic i_id, input logic i_ex,
                       input logic i_mem, input logic ms, input logic ex, input logic [31:0] v);
    rst = r; req_if = i_if; req_id = i_id; req_ex = i_ex; req_mem = i_mem;
    mdu_start = ms; except_occur = ex; except_vec = v;
  endtask

  task automatic check_all(input string tag, input logic [3:0] s, input logic f,
                           input logic [31:0] pc, input logic d, input logic to);
    check({tag, ".stall"}, 32'(stall), 32'(s));
    check({tag, ".flush"}, 32'(flush), 32'(f));
    if (f) check({tag, ".flush_pc"}, flush_pc, pc);
    check({tag, ".mdu_done"}, 32'(mdu_done), 32'(d));
    check({tag, ".timeout"}, 32'(stall_timeout), 32'(to));
  endtask

  // Reference model: remaining MDU hold cycles, a pending-exception slot, a stall run length.
  int          m_mdu_left;
  bit          m_pend;
  logic [31:0] m_pend_vec;
  int          m_run;
  bit          m_to;

  task automatic model_reset();
    m_mdu_left = 0; m_pend = 0; m_pend_vec = '0; m_run = 0; m_to = 0;
  endtask

  task automatic model_step(input string tag);
    logic f, hold, done, s_mem, s_ex, s_id, s_if;
    logic [31:0] pc;
    f = 0; pc = '0;
    if (rst) begin
      check_all(tag, 4'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      model_reset();
      return;
    end
    if (m_pend) begin
      if (!req_mem) begin f = 1; pc = m_pend_vec; end
    end else if (except_occur && !req_mem) begin
      f = 1; pc = except_vec;
    end
    hold = !m_pend && ((m_mdu_left > 0) || (mdu_start && !except_occur));
    done = (m_mdu_left == 1) && !except_occur;
    s_mem = req_mem;
    s_ex  = req_mem | req_ex | hold;
    s_id  = s_ex | req_id;
    s_if  = s_id | req_if;
    if (f) {s_if, s_id, s_ex, s_mem} = 4'b0;
    check_all(tag, {s_if, s_id, s_ex, s_mem}, f, pc, done, m_to);
    if (s_if && !(s_id && !s_ex) && !(s_ex && !s_id)) ; // ordering is implied by construction
    if (f) begin
      m_pend = 0; m_mdu_left = 0;
    end else if (!m_pend && except_occur) begin
      m_pend = 1; m_pend_vec = except_vec; m_mdu_left = 0;
    end else if (!m_pend) begin
      if (m_mdu_left > 0) m_mdu_left--;
      else if (mdu_start) m_mdu_left = MDU - 1;
    end
    m_run = s_if ? ((m_run < LIM) ? m_run + 1 : LIM) : 0;
    if (m_run == LIM) m_to = 1;
  endtask

  vec_t tbl[$];

  initial begin
    // {rst, if, id, ex, mem, mdu_start, except, vec, exp stall{if,id,ex,mem}, flush, pc, done, timeout}
    tbl.push_back('{1,0,0,0,0,0,0,32'h0,        4'b0000,0,32'h0,        0,0});
    tbl.push_back('{0,0,1,0,0,0,0,32'h0,        4'b1100,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,0,1,32'hBFC00380, 4'b0000,1,32'hBFC00380, 0,0});
    tbl.push_back('{0,0,0,0,1,0,1,32'h80000180, 4'b1111,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,1,0,1,32'h80000000, 4'b1111,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,1,0,0,32'h0,        4'b1111,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,0,0,32'h0,        4'b0000,1,32'h80000180, 0,0});
    tbl.push_back('{0,0,0,0,0,1,0,32'h0,        4'b1110,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,1,0,32'h0,        4'b1110,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,0,0,32'h0,        4'b1110,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,0,0,32'h0,        4'b1110,0,32'h0,        1,0});
    tbl.push_back('{0,0,0,0,0,0,0,32'h0,        4'b0000,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,1,0,32'h0,        4'b1110,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,0,0,32'h0,        4'b1110,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,0,1,32'h00000100, 4'b0000,1,32'h00000100, 0,0});
    tbl.push_back('{0,0,0,0,0,0,0,32'h0,        4'b0000,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,0,0,32'h0,        4'b0000,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,1,0,32'h0,        4'b1110,0,32'h0,        0,0});
    tbl.push_back('{1,0,0,0,0,0,0,32'h0,        4'b0000,0,32'h0,        0,0});
    tbl.push_back('{0,0,0,0,0,0,0,32'h0,        4'b0000,0,32'h0,        0,0});

    repeat (2) @(posedge clk);
    for (int k = 0; k < tbl.size(); k++) begin
      #1 drive(tbl[k].r, tbl[k].i_if, tbl[k].i_id, tbl[k].i_ex, tbl[k].i_mem,
               tbl[k].ms, tbl[k].ex, tbl[k].vec);
      #2 check_all($sformatf("vec%0d", k), tbl[k].e_stall, tbl[k].e_flush, tbl[k].e_pc,
                   tbl[k].e_done, tbl[k].e_to);
      @(posedge clk);
    end

    // Watchdog: LIM cycles of IF stall set the sticky flag, release does not clear it.
    for (int k = 0; k < LIM; k++) begin
      #1 drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
      #2 check($sformatf("wdog_pre%0d", k), 32'(stall_timeout), 32'h0);
      @(posedge clk);
    end
    #1 drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    #2 check("wdog_set", 32'(stall_timeout), 32'h1);
    @(posedge clk);
    #3 check("wdog_sticky", 32'(stall_timeout), 32'h1);
    @(posedge clk);
    #1 drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    #2 check("wdog_rst_clear", 32'(stall_timeout), 32'h0);
    @(posedge clk);

    // Random traffic against the model, starting from a known reset.
    #1 drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
    #2 model_step("rst");
    @(posedge clk);
    for (int k = 0; k < 3000; k++) begin
      #1 drive(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 3) == 0) || (k % 500 >= 480 && k % 500 < 495),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 11) == 0),
               $urandom());
      #2 model_step($sformatf("rnd%0d", k));
      @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
